// File: rtl/wb_stage.sv
// Write-back stage: aligns controls with registered memory-stage results, extends loads,
// owns the register file with same-cycle write-to-read bypass, and counts retired instructions.
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 64,
    localparam int AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             regWEn_i,
    input  logic [AW-1:0]    rd_i,
    input  logic [1:0]       wbSel_i,
    input  logic [1:0]       dataSec_i,
    input  logic             unsigned_i,
    input  logic [XLEN-1:0]  pc4_i,
    input  logic [XLEN-1:0]  memData_i,
    input  logic [XLEN-1:0]  alu_i,
    input  logic [AW-1:0]    rs1_i,
    input  logic [AW-1:0]    rs2_i,
    output logic [XLEN-1:0]  rs1Data_o,
    output logic [XLEN-1:0]  rs2Data_o,
    output logic [XLEN-1:0]  wbData_o,
    output logic [AW-1:0]    wbRd_o,
    output logic             wbWEn_o,
    output logic [CNT_W-1:0] instret_o
);

    // valid_i has no backpressure: an instruction presented with valid_i = 1 is always
    // accepted and retires two edges later; upstream squashes by holding valid_i low.
    logic            valid_q;
    logic            regWEn_q;
    logic [AW-1:0]   rd_q;
    logic [1:0]      wbSel_q;
    logic [1:0]      dataSec_q;
    logic            unsigned_q;
    logic [XLEN-1:0] pc4_q;

    logic [XLEN-1:0]  regs [NREG];
    logic [CNT_W-1:0] instret_q;
    logic [XLEN-1:0]  load_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            regWEn_q   <= 1'b0;
            rd_q       <= '0;
            wbSel_q    <= 2'b00;
            dataSec_q  <= 2'b00;
            unsigned_q <= 1'b0;
            pc4_q      <= '0;
        end else begin
            valid_q    <= valid_i;
            regWEn_q   <= regWEn_i;
            rd_q       <= rd_i;
            wbSel_q    <= wbSel_i;
            dataSec_q  <= dataSec_i;
            unsigned_q <= unsigned_i;
            pc4_q      <= pc4_i;
        end
    end

    always_comb begin
        load_val = memData_i;
        case (dataSec_q)
            2'b00: load_val = {{(XLEN-8){memData_i[7] & ~unsigned_q}}, memData_i[7:0]};
            2'b01: load_val = {{(XLEN-16){memData_i[15] & ~unsigned_q}}, memData_i[15:0]};
            default: load_val = memData_i;
        endcase
    end

    always_comb begin
        wbData_o = alu_i;
        case (wbSel_q)
            2'b00:   wbData_o = load_val;
            2'b10:   wbData_o = pc4_q;
            default: wbData_o = alu_i;
        endcase
    end

    assign wbRd_o  = rd_q;
    // Reset masks the write so a pending instruction in ctl_q is dropped outright.
    assign wbWEn_o = valid_q & regWEn_q & (rd_q != '0) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wbWEn_o) begin
            regs[rd_q] <= wbData_o;
        end
    end

    always_comb begin
        rs1Data_o = regs[rs1_i];
        if (rs1_i == '0) begin
            rs1Data_o = '0;
        end else if (wbWEn_o && (rs1_i == rd_q)) begin
            rs1Data_o = wbData_o;
        end
    end

    always_comb begin
        rs2Data_o = regs[rs2_i];
        if (rs2_i == '0) begin
            rs2Data_o = '0;
        end else if (wbWEn_o && (rs2_i == rd_q)) begin
            rs2Data_o = wbData_o;
        end
    end

    // Every valid instruction retires, including x0 writes and non-writing ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (valid_q) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign instret_o = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset state, ALU/load/JAL write-back, bypass, x0, and
// reset arriving while a write is pending.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, regWEn_i, unsigned_i;
    logic [4:0]  rd_i, rs1_i, rs2_i;
    logic [1:0]  wbSel_i, dataSec_i;
    logic [31:0] pc4_i, memData_i, alu_i;
    logic [31:0] rs1Data_o, rs2Data_o, wbData_o;
    logic [4:0]  wbRd_o;
    logic        wbWEn_o;
    logic [63:0] instret_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_instret;
    logic [31:0] vals [4];

    wb_stage dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .regWEn_i(regWEn_i), .rd_i(rd_i),
        .wbSel_i(wbSel_i), .dataSec_i(dataSec_i), .unsigned_i(unsigned_i),
        .pc4_i(pc4_i), .memData_i(memData_i), .alu_i(alu_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i),
        .rs1Data_o(rs1Data_o), .rs2Data_o(rs2Data_o),
        .wbData_o(wbData_o), .wbRd_o(wbRd_o), .wbWEn_o(wbWEn_o),
        .instret_o(instret_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ctl(input logic v, input logic w, input logic [4:0] rd,
                             input logic [1:0] sel, input logic [1:0] sec,
                             input logic uns, input logic [31:0] pc4);
        valid_i = v; regWEn_i = w; rd_i = rd; wbSel_i = sel;
        dataSec_i = sec; unsigned_i = uns; pc4_i = pc4;
        if (v) exp_instret = exp_instret + 64'd1;
    endtask

    task automatic idle_ctl();
        drive_ctl(1'b0, 1'b0, 5'd0, 2'b00, 2'b00, 1'b0, 32'h0);
    endtask

    initial begin
        exp_instret = 64'd0;
        rst = 1'b1;
        idle_ctl();
        memData_i = 32'h0; alu_i = 32'h0; rs1_i = 5'd0; rs2_i = 5'd0;
        tick(); tick();
        rst = 1'b0;
        #1;

        // 1. reset state
        for (int i = 0; i < 32; i++) begin
            rs1_i = 5'(i); rs2_i = 5'(31 - i);
            #1;
            check($sformatf("reset_rs1_%0d", i), {32'h0, rs1Data_o}, 64'h0);
            check($sformatf("reset_rs2_%0d", 31 - i), {32'h0, rs2Data_o}, 64'h0);
        end
        check("reset_instret", instret_o, 64'h0);
        check("reset_wben", {63'h0, wbWEn_o}, 64'h0);
        check("reset_wbrd", {59'h0, wbRd_o}, 64'h0);

        // 2. ALU write to x5
        drive_ctl(1'b1, 1'b1, 5'd5, 2'b01, 2'b00, 1'b0, 32'h0);
        tick();
        idle_ctl();
        alu_i = 32'h1234_5678;
        rs1_i = 5'd5;
        #1;
        check("alu_wben", {63'h0, wbWEn_o}, 64'h1);
        check("alu_wbrd", {59'h0, wbRd_o}, 64'd5);
        check("alu_wbdata", {32'h0, wbData_o}, 64'h1234_5678);
        check("alu_bypass", {32'h0, rs1Data_o}, 64'h1234_5678);
        tick();
        alu_i = 32'h0;
        #1;
        check("alu_regs5", {32'h0, rs1Data_o}, 64'h1234_5678);
        check("alu_wben_after", {63'h0, wbWEn_o}, 64'h0);
        check("alu_instret", instret_o, 64'd1);

        // 3. loads, issued back to back
        drive_ctl(1'b1, 1'b1, 5'd8, 2'b00, 2'b00, 1'b0, 32'h0);   // LB
        tick();
        memData_i = 32'h0000_0080;
        drive_ctl(1'b1, 1'b1, 5'd9, 2'b00, 2'b00, 1'b1, 32'h0);   // LBU
        #1;
        check("lb_data", {32'h0, wbData_o}, 64'hFFFF_FF80);
        tick();
        memData_i = 32'h0000_0080;
        drive_ctl(1'b1, 1'b1, 5'd10, 2'b00, 2'b01, 1'b0, 32'h0);  // LH
        #1;
        check("lbu_data", {32'h0, wbData_o}, 64'h0000_0080);
        tick();
        memData_i = 32'h0000_8001;
        drive_ctl(1'b1, 1'b1, 5'd12, 2'b00, 2'b01, 1'b1, 32'h0);  // LHU
        #1;
        check("lh_data", {32'h0, wbData_o}, 64'hFFFF_8001);
        tick();
        memData_i = 32'h0000_8001;
        drive_ctl(1'b1, 1'b1, 5'd13, 2'b00, 2'b10, 1'b0, 32'h0);  // LW
        #1;
        check("lhu_data", {32'h0, wbData_o}, 64'h0000_8001);
        tick();
        memData_i = 32'h8000_00F0;
        idle_ctl();
        #1;
        check("lw_data", {32'h0, wbData_o}, 64'h8000_00F0);
        tick();
        memData_i = 32'h0;
        rs1_i = 5'd8; rs2_i = 5'd9;
        #1;
        check("lb_regs8", {32'h0, rs1Data_o}, 64'hFFFF_FF80);
        check("lbu_regs9", {32'h0, rs2Data_o}, 64'h0000_0080);
        rs1_i = 5'd10; rs2_i = 5'd13;
        #1;
        check("lh_regs10", {32'h0, rs1Data_o}, 64'hFFFF_8001);
        check("lw_regs13", {32'h0, rs2Data_o}, 64'h8000_00F0);
        check("load_instret", instret_o, exp_instret);

        // 4. dual bypass and x0
        drive_ctl(1'b1, 1'b1, 5'd7, 2'b01, 2'b00, 1'b0, 32'h0);
        tick();
        idle_ctl();
        alu_i = 32'hA5A5_A5A5;
        rs1_i = 5'd7; rs2_i = 5'd7;
        #1;
        check("bypass_rs1", {32'h0, rs1Data_o}, 64'hA5A5_A5A5);
        check("bypass_rs2", {32'h0, rs2Data_o}, 64'hA5A5_A5A5);
        tick();
        drive_ctl(1'b1, 1'b1, 5'd0, 2'b01, 2'b00, 1'b0, 32'h0);
        alu_i = 32'h0;
        tick();
        idle_ctl();
        alu_i = 32'h0000_DEAD;
        rs1_i = 5'd0;
        #1;
        check("x0_wben", {63'h0, wbWEn_o}, 64'h0);
        check("x0_rs1", {32'h0, rs1Data_o}, 64'h0);
        check("x7_held", {32'h0, rs2Data_o}, 64'hA5A5_A5A5);
        tick();
        alu_i = 32'h0;
        #1;
        check("x0_instret", instret_o, exp_instret);
        check("x0_rs1_after", {32'h0, rs1Data_o}, 64'h0);

        // 5. JAL link, then back-to-back ALU writes
        drive_ctl(1'b1, 1'b1, 5'd1, 2'b10, 2'b00, 1'b0, 32'h0000_0104);
        tick();
        idle_ctl();
        pc4_i = 32'hDEAD_BEEF;
        alu_i = 32'h5555_0000;
        #1;
        check("jal_wbdata", {32'h0, wbData_o}, 64'h0000_0104);
        tick();
        rs1_i = 5'd1;
        #1;
        check("jal_regs1", {32'h0, rs1Data_o}, 64'h0000_0104);

        vals[0] = 32'h1111_0001; vals[1] = 32'h2222_0002;
        vals[2] = 32'h3333_0003; vals[3] = 32'h4444_0004;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive_ctl(1'b1, 1'b1, 5'(20 + i), 2'b11, 2'b00, 1'b0, 32'h0);
            else       idle_ctl();
            if (i > 0) begin
                alu_i = vals[i - 1];
                #1;
                check($sformatf("b2b_wben_%0d", i), {63'h0, wbWEn_o}, 64'h1);
                check($sformatf("b2b_wbdata_%0d", i), {32'h0, wbData_o}, {32'h0, vals[i - 1]});
                check($sformatf("b2b_wbrd_%0d", i), {59'h0, wbRd_o}, 64'(20 + i - 1));
            end
            tick();
        end
        #1;
        check("b2b_instret", instret_o, exp_instret);
        for (int i = 0; i < 4; i++) begin
            rs1_i = 5'(20 + i);
            #1;
            check($sformatf("b2b_regs_%0d", 20 + i), {32'h0, rs1Data_o}, {32'h0, vals[i]});
        end

        // 6. reset while a write to x3 is pending
        drive_ctl(1'b1, 1'b1, 5'd3, 2'b01, 2'b00, 1'b0, 32'h0);
        tick();
        idle_ctl();
        rst = 1'b1;
        alu_i = 32'h3333_3333;
        rs1_i = 5'd3;
        #1;
        check("rst_pending_wben", {63'h0, wbWEn_o}, 64'h0);
        check("rst_pending_nobypass", {32'h0, rs1Data_o}, 64'h0);
        tick();
        rst = 1'b0;
        exp_instret = 64'd0;
        rs2_i = 5'd5;
        #1;
        check("post_rst_wben", {63'h0, wbWEn_o}, 64'h0);
        check("post_rst_regs3", {32'h0, rs1Data_o}, 64'h0);
        check("post_rst_regs5", {32'h0, rs2Data_o}, 64'h0);
        check("post_rst_instret", instret_o, exp_instret);
        check("post_rst_wbrd", {59'h0, wbRd_o}, 64'h0);
        tick();
        #1;
        check("post_rst_regs3_later", {32'h0, rs1Data_o}, 64'h0);
        check("post_rst_instret_later", instret_o, exp_instret);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
